// File: rtl/draw_ball.sv
// draw_ball: overlays a bouncing ball on the upstream pixel stream.
// The ball waits centred in IDLE and launches on serve_in. In MOVE it bounces
// off the top and bottom edges. Reaching the left or right edge is a miss:
// the ball vanishes for MISS_FRAMES frames and then re-centres.
// Every output is registered, so the stream is delayed by one pclk.
// Optional macro DRAW_BALL_ROUND_EN: trims the box corners to draw a
// rounded ball. Motion and latency do not change.
module draw_ball #(
  parameter int          BALL_SIZE   = 16,
  parameter int          SPEED       = 4,
  parameter int          MISS_FRAMES = 60,
  parameter logic [11:0] BALL_RGB    = 12'hf_f_f
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        serve_in,
  input  logic        serve_dir_in,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  output logic        miss_left,
  output logic        miss_right,
  output logic        busy
);

  // Comparisons use 12 bits so that position + step never wraps.
  localparam logic [11:0] BSZ    = 12'(BALL_SIZE);
  localparam logic [11:0] SPD    = 12'(SPEED);
  localparam logic [10:0] SPD_S  = 11'(SPEED);
  localparam logic [11:0] X_MAX  = 12'(1024 - BALL_SIZE);
  localparam logic [11:0] Y_MAX  = 12'(768 - BALL_SIZE);
  localparam logic [10:0] Y_MAX_S = 11'(768 - BALL_SIZE);
  localparam logic [10:0] X_MID  = 11'((1024 - BALL_SIZE) / 2);
  localparam logic [10:0] Y_MID  = 11'((768 - BALL_SIZE) / 2);
  localparam int          CW     = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, MISS = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [10:0]   ball_x, ball_y, x_nxt, y_nxt;
  logic          dir_x, dir_y, dx_nxt, dy_nxt;   // dir_x 1 = right, dir_y 1 = down
  logic [CW-1:0] cnt, cnt_nxt;

  logic          frame_tick;
  logic [11:0]   x_ext, y_ext;
  logic          hit_right, hit_left, miss_now, miss_done;
  logic          in_box, corner_cut, draw;
  logic [11:0]   rgb_nxt;

  assign frame_tick = (vcount_in == 11'd768) && (hcount_in == 11'd0);
  assign x_ext      = {1'b0, ball_x};
  assign y_ext      = {1'b0, ball_y};

  // A miss is decided before any subtraction, so the ball never leaves the screen.
  assign hit_right = dir_x  && ((x_ext + SPD) > X_MAX);
  assign hit_left  = !dir_x && (x_ext < SPD);
  assign miss_now  = (state == MOVE) && frame_tick && (hit_right || hit_left);
  assign miss_done = (state == MISS) && frame_tick && (cnt == CNT_LAST);

  // State register
  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (serve_in)  state_nxt = MOVE;
      MOVE:    if (miss_now)  state_nxt = MISS;
      MISS:    if (miss_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next ball position, direction and miss-frame count
  always_comb begin
    x_nxt   = ball_x;
    y_nxt   = ball_y;
    dx_nxt  = dir_x;
    dy_nxt  = dir_y;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: begin
        x_nxt = X_MID;
        y_nxt = Y_MID;
        if (serve_in) begin
          dx_nxt = serve_dir_in;
          dy_nxt = 1'b1;
        end
      end
      MOVE: begin
        if (miss_now) begin
          // A miss wins: the vertical move on this tick is dropped.
          cnt_nxt = '0;
        end else if (frame_tick) begin
          x_nxt = dir_x ? (ball_x + SPD_S) : (ball_x - SPD_S);
          if (dir_y) begin
            if ((y_ext + SPD) > Y_MAX) begin
              y_nxt  = Y_MAX_S;
              dy_nxt = 1'b0;
            end else begin
              y_nxt = ball_y + SPD_S;
            end
          end else begin
            if (y_ext < SPD) begin
              y_nxt  = '0;
              dy_nxt = 1'b1;
            end else begin
              y_nxt = ball_y - SPD_S;
            end
          end
        end
      end
      MISS: begin
        if (miss_done) begin
          x_nxt   = X_MID;
          y_nxt   = Y_MID;
          cnt_nxt = '0;
        end else if (frame_tick) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Ball position, direction and miss-frame counter registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      ball_x <= X_MID;
      ball_y <= Y_MID;
      dir_x  <= 1'b1;
      dir_y  <= 1'b1;
      cnt    <= '0;
    end else begin
      ball_x <= x_nxt;
      ball_y <= y_nxt;
      dir_x  <= dx_nxt;
      dir_y  <= dy_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Test whether the current pixel falls inside the ball's bounding box
  always_comb begin
    in_box = ({1'b0, hcount_in} >= x_ext) && ({1'b0, hcount_in} < (x_ext + BSZ)) &&
             ({1'b0, vcount_in} >= y_ext) && ({1'b0, vcount_in} < (y_ext + BSZ));
  end

`ifdef DRAW_BALL_ROUND_EN
  localparam logic [10:0] B_LAST  = 11'(BALL_SIZE - 1);
  localparam logic [11:0] QUARTER = 12'(BALL_SIZE / 4);
  logic [10:0] off_x, off_y, edge_x, edge_y;

  // Distance to the nearest box edge on each axis. Small sums mark corner pixels.
  // Offsets are meaningless outside the box, but in_box masks that case.
  always_comb begin
    off_x      = hcount_in - ball_x;
    off_y      = vcount_in - ball_y;
    edge_x     = (off_x < (B_LAST - off_x)) ? off_x : (B_LAST - off_x);
    edge_y     = (off_y < (B_LAST - off_y)) ? off_y : (B_LAST - off_y);
    corner_cut = ({1'b0, edge_x} + {1'b0, edge_y}) < QUARTER;
  end
`else
  assign corner_cut = 1'b0;
`endif

  // Pixel composite: ball colour over the background while visible
  always_comb begin
    draw    = in_box && !corner_cut && (state != MISS) && !vblnk_in && !hblnk_in;
    rgb_nxt = draw ? BALL_RGB : rgb_in;
  end

  // Output register: one-cycle delay of the timing stream plus status pulses
  always_ff @(posedge pclk) begin
    if (rst) begin
      vcount_out <= '0;
      hcount_out <= '0;
      vsync_out  <= 1'b0;
      hsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= '0;
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vcount_out <= vcount_in;
      hcount_out <= hcount_in;
      vsync_out  <= vsync_in;
      hsync_out  <= hsync_in;
      vblnk_out  <= vblnk_in;
      hblnk_out  <= hblnk_in;
      rgb_out    <= rgb_nxt;
      miss_left  <= miss_now && !dir_x;
      miss_right <= miss_now && dir_x;
      busy       <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_draw_ball.sv
// tb_draw_ball: random pixel probes around a behavioural ball model.
// u_dut uses the default parameters. u_fast (SPEED 256) reaches a
// simultaneous bottom bounce and right miss on its second tick.
module tb_draw_ball;

  localparam logic [11:0] BALL = 12'hfff;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 1'b0, hsync_in = 1'b0, vblnk_in = 1'b0, hblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        serve_in = 1'b0, serve_dir_in = 1'b0;

  logic [10:0] vcount_out, hcount_out, f_vcount, f_hcount;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic        f_vsync, f_hsync, f_vblnk, f_hblnk;
  logic [11:0] rgb_out, f_rgb;
  logic        miss_left, miss_right, busy, f_ml, f_mr, f_busy;

  always #5 pclk = ~pclk;

  draw_ball u_dut (
    .pclk(pclk), .rst(rst),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .serve_in(serve_in), .serve_dir_in(serve_dir_in),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .miss_left(miss_left), .miss_right(miss_right), .busy(busy)
  );

  draw_ball #(.SPEED(256), .MISS_FRAMES(3)) u_fast (
    .pclk(pclk), .rst(rst),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .serve_in(serve_in), .serve_dir_in(serve_dir_in),
    .vcount_out(f_vcount), .hcount_out(f_hcount),
    .vsync_out(f_vsync), .hsync_out(f_hsync), .vblnk_out(f_vblnk), .hblnk_out(f_hblnk),
    .rgb_out(f_rgb), .miss_left(f_ml), .miss_right(f_mr), .busy(f_busy)
  );

  logic [40:0] obs_d, exp_d;
  logic [14:0] obs_f, exp_f;
  assign obs_d = {rgb_out, busy, miss_left, miss_right, vcount_out, hcount_out,
                  vsync_out, hsync_out, vblnk_out, hblnk_out};
  assign obs_f = {f_rgb, f_busy, f_ml, f_mr};

  int n_cmp = 0;
  int n_bad = 0;

  // Model: st 0 = waiting, 1 = flying, 2 = missed. dx/dy are signed unit directions.
  typedef struct { int st; int x; int y; int dx; int dy; int cnt; } mdl_t;
  mdl_t md, mf;

  // Probe offsets that pin the ball edges. All lie on the box midlines, so
  // they stay valid when the corners are rounded.
  int ox_t[8] = '{0, -1, 8,  8, 15, 16,  8,  8};
  int oy_t[8] = '{8,  8, 0, -1,  8,  8, 15, 16};

  function automatic mdl_t m_reset(int b);
    mdl_t m;
    m.st = 0; m.x = (1024 - b) / 2; m.y = (768 - b) / 2;
    m.dx = 1; m.dy = 1; m.cnt = 0;
    return m;
  endfunction

  function automatic mdl_t m_next(mdl_t m, int b, int s, int mfr, bit tick, bit srv,
                                  bit sdir, output bit ml, output bit mr);
    mdl_t n = m;
    int nx, ny;
    ml = 0; mr = 0;
    if (m.st == 0) begin
      if (srv) begin n.st = 1; n.dx = sdir ? 1 : -1; n.dy = 1; end
    end else if (m.st == 1) begin
      if (tick) begin
        nx = m.x + m.dx * s;
        if (nx < 0 || nx > 1024 - b) begin
          n.st = 2; n.cnt = 0;
          if (m.dx > 0) mr = 1; else ml = 1;
        end else begin
          n.x = nx;
          ny = m.y + m.dy * s;
          if (ny > 768 - b)  begin n.y = 768 - b; n.dy = -1; end
          else if (ny < 0)   begin n.y = 0;       n.dy = 1;  end
          else n.y = ny;
        end
      end
    end else if (tick) begin
      if (m.cnt == mfr - 1) n = m_reset(b);
      else n.cnt = m.cnt + 1;
    end
    return n;
  endfunction

  function automatic bit m_pix(mdl_t m, int b, int h, int v);
    int ox, oy;
    if (m.st == 2) return 0;
    if (h < m.x || h >= m.x + b || v < m.y || v >= m.y + b) return 0;
    ox = h - m.x; oy = v - m.y;
`ifdef DRAW_BALL_ROUND_EN
    if (((ox < b - 1 - ox) ? ox : b - 1 - ox) + ((oy < b - 1 - oy) ? oy : b - 1 - oy) < b / 4)
      return 0;
`endif
    return 1;
  endfunction

  // Drive one pixel cycle, advance both models, and leave expectations in exp_d/exp_f.
  task automatic step(input int h, input int v, input bit vb, input bit hb,
                      input bit srv, input bit sdir);
    bit tick, ml, mr, fml, fmr, bd, bf;
    logic [11:0] rd, rf;
    @(negedge pclk);
    hcount_in = 11'(h); vcount_in = 11'(v);
    vblnk_in = vb; hblnk_in = hb; serve_in = srv; serve_dir_in = sdir;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom); rgb_in = 12'($urandom);
    tick = (h == 0 && v == 768);
    if (rst) begin
      exp_d = '0; exp_f = '0;
      md = m_reset(16); mf = m_reset(16);
    end else begin
      rd = (!vb && !hb && m_pix(md, 16, h, v)) ? BALL : rgb_in;
      rf = (!vb && !hb && m_pix(mf, 16, h, v)) ? BALL : rgb_in;
      bd = (md.st != 0); bf = (mf.st != 0);
      md = m_next(md, 16, 4, 60, tick, srv, sdir, ml, mr);
      mf = m_next(mf, 16, 256, 3, tick, srv, sdir, fml, fmr);
      exp_d = {rd, bd, ml, mr, vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in};
      exp_f = {rf, bf, fml, fmr};
    end
    @(posedge pclk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step($urandom_range(0, 1023), $urandom_range(0, 767), 0, 0, 1, 1);
      n_cmp++;
      if (obs_d !== exp_d || obs_f !== exp_f) begin
        n_bad++;
        $display("FAIL reset got %h/%h want %h/%h", obs_d, obs_f, exp_d, exp_f);
      end
    end
  endtask

  task automatic test_idle();
    int h, v;
    bit hb;
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      step(0, 768, 1, 1, 0, 0);
      n_cmp++;
      if (obs_d !== exp_d) begin
        n_bad++; $display("FAIL idle_tick got %h want %h", obs_d, exp_d);
      end
    end
    for (int k = 0; k < 30; k++) begin
      hb = 0;
      if (k < 8) begin h = md.x + ox_t[k]; v = md.y + oy_t[k]; end
      else if (k == 8)  begin h = 504; v = 376; end
      else if (k == 9)  begin h = 519; v = 391; end
      else if (k == 10) begin h = 512; v = 384; hb = 1; end
      else begin h = $urandom_range(496, 527); v = $urandom_range(368, 399); hb = ($urandom_range(0, 5) == 0); end
      step(h, v, 0, hb, 0, 0);
      n_cmp++;
      if (obs_d !== exp_d) begin
        n_bad++; $display("FAIL idle_pix h=%0d v=%0d got %h want %h", h, v, obs_d, exp_d);
      end
    end
  endtask

  // Serve, then fly until the model registers a miss, probing the ball edges each frame.
  task automatic test_serve_flight(input bit dir);
    int h, v;
    step(100, 100, 0, 0, 1, dir);
    n_cmp++;
    if (obs_d !== exp_d) begin
      n_bad++; $display("FAIL serve got %h want %h", obs_d, exp_d);
    end
    for (int f = 0; f < 300 && md.st == 1; f++) begin
      step(0, 768, 1, 1, 0, 0);
      n_cmp++;
      if (obs_d !== exp_d) begin
        n_bad++; $display("FAIL flight_tick f=%0d got %h want %h", f, obs_d, exp_d);
      end
      if (md.st == 1) begin
        for (int k = 0; k < 8; k++) begin
          h = md.x + ox_t[k]; v = md.y + oy_t[k];
          step(h, v, 0, 0, (k == 3), ~dir);
          n_cmp++;
          if (obs_d !== exp_d) begin
            n_bad++; $display("FAIL flight_pix f=%0d h=%0d v=%0d got %h want %h", f, h, v, obs_d, exp_d);
          end
        end
      end
    end
  endtask

  // Sit out the miss period and check that the ball is hidden, then re-centred.
  task automatic test_miss(input int max_frames);
    for (int f = 0; f < max_frames && md.st == 2; f++) begin
      step(0, 768, 1, 1, 0, 0);
      n_cmp++;
      if (obs_d !== exp_d) begin
        n_bad++; $display("FAIL miss_tick f=%0d got %h want %h", f, obs_d, exp_d);
      end
      step(md.x + 8, md.y + 8, 0, 0, 0, 0);
      n_cmp++;
      if (obs_d !== exp_d) begin
        n_bad++; $display("FAIL miss_pix f=%0d got %h want %h", f, obs_d, exp_d);
      end
    end
    if (md.st == 0) begin
      for (int k = 0; k < 8; k++) begin
        step(504 + ox_t[k], 376 + oy_t[k], 0, 0, 0, 0);
        n_cmp++;
        if (obs_d !== exp_d) begin
          n_bad++; $display("FAIL recentre k=%0d got %h want %h", k, obs_d, exp_d);
        end
      end
    end
  endtask

  task automatic test_rst_miss();
    rst = 1'b1;
    step(0, 768, 1, 1, 0, 0);
    n_cmp++;
    if (obs_d !== exp_d || obs_f !== exp_f) begin
      n_bad++; $display("FAIL rst_miss got %h/%h want %h/%h", obs_d, obs_f, exp_d, exp_f);
    end
    rst = 1'b0;
    step(504, 376, 0, 0, 0, 0);
    n_cmp++;
    if (obs_d !== exp_d) begin
      n_bad++; $display("FAIL corner got %h want %h", obs_d, exp_d);
    end
    step(512, 384, 0, 0, 0, 0);
    n_cmp++;
    if (obs_d !== exp_d) begin
      n_bad++; $display("FAIL centre got %h want %h", obs_d, exp_d);
    end
  endtask

  // u_fast: the second tick is both a bottom bounce and a right miss.
  task automatic test_simul();
    step(200, 200, 0, 0, 1, 1);
    for (int f = 0; f < 3; f++) begin
      step(0, 768, 1, 1, 0, 0);
      n_cmp++;
      if (obs_f !== exp_f) begin
        n_bad++; $display("FAIL simul_tick f=%0d got %h want %h", f, obs_f, exp_f);
      end
      step(768, 640, 0, 0, 0, 0);
      n_cmp++;
      if (obs_f !== exp_f) begin
        n_bad++; $display("FAIL simul_pix f=%0d got %h want %h", f, obs_f, exp_f);
      end
    end
  endtask

  initial begin
    md = m_reset(16);
    mf = m_reset(16);
    exp_d = '0;
    exp_f = '0;
    test_reset();
    test_idle();
    test_serve_flight(1'b1);
    test_miss(70);
    test_serve_flight(1'b0);
    test_miss(5);
    test_rst_miss();
    test_simul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_ball.md
DRAW_BALL -- requirements
Module: draw_ball

Interface
REQ-001 Clock pclk; reset rst, synchronous, active-high.
REQ-002 Parameters (name, default, meaning):
- BALL_SIZE, 16: ball box side in pixels.
- SPEED, 4: pixels moved per axis per frame.
- MISS_FRAMES, 60: frames spent in MISS.
- BALL_RGB, 12'hf_f_f: ball colour.
REQ-003 Ports (name  direction  width  meaning):
- pclk  in  1  pixel clock.
- rst  in  1  sync reset.
- vcount_in, hcount_in  in  11 each  timing counters.
- vsync_in, hsync_in, vblnk_in, hblnk_in  in  1 each  timing flags.
- rgb_in  in  12  background pixel from the upstream background stage.
- serve_in  in  1  launch request.
- serve_dir_in  in  1  horizontal launch direction, 0 = left, 1 = right.
- vcount_out, hcount_out  out  11 each  delayed counters.
- vsync_out, hsync_out, vblnk_out, hblnk_out  out  1 each  delayed flags.
- rgb_out  out  12  composited pixel.
- miss_left, miss_right  out  1 each  one-cycle miss pulses.
- busy  out  1  high when not IDLE.

Function
REQ-004 All outputs are registered, with latency exactly 1 pclk; counters, sync and blank flags pass through unchanged.
REQ-005 Active area is 1024x768 (hcount 0..1023, vcount 0..767).
REQ-006 frame_tick is asserted for one cycle when vcount_in == 768 and hcount_in == 0; ball position changes only on frame_tick or on a state entry.
REQ-007 Ball pixel condition: ball_x <= hcount_in < ball_x + BALL_SIZE and ball_y <= vcount_in < ball_y + BALL_SIZE.
REQ-008 rgb_out = BALL_RGB when the ball pixel condition holds, state != MISS, and vblnk_in = hblnk_in = 0; otherwise rgb_out = rgb_in.
REQ-009 States: IDLE, MOVE, MISS.
REQ-010 IDLE: ball_x = (1024-BALL_SIZE)/2 (504) and ball_y = (768-BALL_SIZE)/2 (376); the ball is drawn stationary.
REQ-011 IDLE -> MOVE on any cycle with serve_in = 1:
- dir_x latched from serve_dir_in;
- dir_y = down.
- serve_in is ignored outside IDLE.
REQ-012 MOVE vertical motion on frame_tick:
- Down: if ball_y + SPEED > 768-BALL_SIZE, then ball_y = 768-BALL_SIZE and dir_y = up; else ball_y += SPEED.
- Up: if ball_y < SPEED, then ball_y = 0 and dir_y = down; else ball_y -= SPEED.
REQ-013 MOVE horizontal motion on frame_tick:
- Right: if ball_x + SPEED > 1024-BALL_SIZE, go to MISS and pulse miss_right; else ball_x += SPEED.
- Left: if ball_x < SPEED, go to MISS and pulse miss_left; else ball_x -= SPEED.
REQ-014 A vertical bounce and a horizontal miss on the same tick: the miss takes priority and the vertical update is discarded.
REQ-015 MISS: ball not drawn; a frame counter loads 0 on entry and increments on each frame_tick; at count MISS_FRAMES-1 plus a tick, go to IDLE (ball recentred).
REQ-016 miss_left and miss_right are high for exactly one cycle, never simultaneously; busy = (state != IDLE).
REQ-017 Position arithmetic is 11-bit unsigned with comparisons done before subtraction, so no wrap-around occurs.

Reset
REQ-018 On rst:
- state = IDLE; ball recentred; dir_x = right, dir_y = down; frame counter = 0.
- All outputs = 0, including rgb_out, counters, flags, pulses and busy.
REQ-019 rst mid-MOVE or mid-MISS aborts immediately; no miss pulse is issued.

Configuration
REQ-020 Macro DRAW_BALL_ROUND_EN:
- Defined: a ball pixel at offset (ox, oy) within the box is suppressed when min(ox, BALL_SIZE-1-ox) + min(oy, BALL_SIZE-1-oy) < BALL_SIZE/4, giving a rounded ball.
- Undefined: the full square box is drawn.
- Motion and latency are identical in both cases.

Verification
REQ-021 Reset, then idle frames -> rgb_out = BALL_RGB at (504..519, 376..391) one cycle later; rgb_out = rgb_in elsewhere; busy = 0.
REQ-022 serve_in = 1, serve_dir_in = 1 -> after the first frame_tick ball at (508, 380); busy = 1.
REQ-023 Ball moving down at y = 750 -> next tick y = 752 and dir up; following tick y = 748.
REQ-024 Ball moving right at x = 1006 -> next tick MISS; miss_right high for 1 cycle; ball absent for 60 frames; then IDLE at (504, 376).
REQ-025 Bottom bounce and right miss on the same tick -> MISS entered; y unchanged; only miss_right pulses.
REQ-026 rst asserted mid-MISS -> next cycle state IDLE, all outputs 0, no miss pulse; with DRAW_BALL_ROUND_EN defined, corner pixel (504, 376) shows rgb_in.
